// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the register-file write-arbiter signals: primary writeback,
// secondary result handshake, issue tracking, decode hazard check and the
// regfile write port. The master side drives the requests; the slave side
// (the arbiter) drives the port, the handshake responses and the hazard flag.
interface regfile_write_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    // primary writeback
    logic                  p_we;
    logic [ADDR_WIDTH-1:0] p_rd;
    logic [DATA_WIDTH-1:0] p_wd;
    logic                  p_stall;
    // secondary result stream
    logic                  s_valid;
    logic                  s_ready;
    logic [ADDR_WIDTH-1:0] s_rd;
    logic [DATA_WIDTH-1:0] s_wd;
    // long-operation issue and decode check
    logic                  s_issue;
    logic [ADDR_WIDTH-1:0] s_issue_rd;
    logic [ADDR_WIDTH-1:0] chk_rs1;
    logic [ADDR_WIDTH-1:0] chk_rs2;
    logic                  hazard;
    // regfile write port
    logic [ADDR_WIDTH-1:0] A3;
    logic [DATA_WIDTH-1:0] WD3;
    logic                  WE3;
    logic                  init_busy;

    modport master (
        output p_we, p_rd, p_wd, s_valid, s_rd, s_wd,
               s_issue, s_issue_rd, chk_rs1, chk_rs2,
        input  p_stall, s_ready, hazard, A3, WD3, WE3, init_busy
    );

    modport slave (
        input  p_we, p_rd, p_wd, s_valid, s_rd, s_wd,
               s_issue, s_issue_rd, chk_rs1, chk_rs2,
        output p_stall, s_ready, hazard, A3, WD3, WE3, init_busy
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shared write-port sequencer/arbiter for the 32x32 register file.
// After reset it zeroes x1..x31, then arbitrates the single write port
// between the pipeline writeback (fixed priority) and a small FIFO fed by
// a multi-cycle unit, with a starvation escape for the FIFO and a pending
// destination scoreboard used by decode to stall on outstanding results.
// Port selection is combinational so the regfile (which commits on the
// falling edge) sees a stable A3/WD3/WE3 for the whole high phase.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    regfile_write_arbiter_if.slave bus
);

    localparam int NREG  = 1 << ADDR_WIDTH;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

    localparam logic [ADDR_WIDTH-1:0] IDX_ZERO  = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] IDX_LAST  = {ADDR_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [PTR_W-1:0]      PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [ST_W-1:0]       ST_ONE    = ST_W'(1);
    localparam logic [ST_W-1:0]       ST_LIMIT  = ST_W'(STARVE_LIMIT);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // sequencer state
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;

    // secondary FIFO
    logic [ADDR_WIDTH-1:0] fifo_rd_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_wd_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    // starvation counter, scoreboard and last-driven port values
    logic [ST_W-1:0]       starve_q, starve_d;
    logic [NREG-1:0]       pending_q, pending_d;
    logic [ADDR_WIDTH-1:0] hold_a3_q, hold_a3_d;
    logic [DATA_WIDTH-1:0] hold_wd3_q, hold_wd3_d;

    // combinational decisions
    logic                  run_s;
    logic                  fifo_empty_s;
    logic                  fifo_full_s;
    logic                  force_s;
    logic                  stall_s;
    logic                  prim_win_s;
    logic                  pop_s;
    logic                  push_s;
    logic [ADDR_WIDTH-1:0] head_rd_s;
    logic [DATA_WIDTH-1:0] head_wd_s;
    logic                  we3_s;
    logic [ADDR_WIDTH-1:0] a3_s;
    logic [DATA_WIDTH-1:0] wd3_s;
    logic                  drive_s;

    assign run_s        = (state_q == ST_RUN);
    assign fifo_empty_s = (count_q == {CNT_W{1'b0}});
    assign fifo_full_s  = (count_q == CNT_FULL);
    assign head_rd_s    = fifo_rd_q[rd_ptr_q];
    assign head_wd_s    = fifo_wd_q[rd_ptr_q];

    // Port arbitration: primary first, then the FIFO head; a starved full
    // FIFO steals one cycle by stalling the primary.
    always_comb begin
        force_s    = run_s && (starve_q == ST_LIMIT);
        stall_s    = !run_s || force_s;
        prim_win_s = run_s && bus.p_we && (bus.p_rd != IDX_ZERO) && !stall_s;
        pop_s      = run_s && !prim_win_s && !fifo_empty_s;
        push_s     = run_s && bus.s_valid && !fifo_full_s;
    end

    // Write-port mux; in CLEAR the port walks idx with zero data (gated off
    // while rst_n is low), otherwise the winner drives or the port holds.
    always_comb begin
        we3_s   = 1'b0;
        a3_s    = hold_a3_q;
        wd3_s   = hold_wd3_q;
        drive_s = 1'b0;
        if (!run_s) begin
            we3_s   = rst_n;
            a3_s    = rst_n ? idx_q : IDX_ZERO;
            wd3_s   = DATA_ZERO;
            drive_s = rst_n;
        end else if (prim_win_s) begin
            we3_s   = 1'b1;
            a3_s    = bus.p_rd;
            wd3_s   = bus.p_wd;
            drive_s = 1'b1;
        end else if (pop_s) begin
            // x0 entries are retired without a regfile write
            we3_s   = (head_rd_s != IDX_ZERO);
            a3_s    = head_rd_s;
            wd3_s   = head_wd_s;
            drive_s = 1'b1;
        end else begin
            we3_s   = 1'b0;
            drive_s = 1'b0;
        end
    end

    // Hold registers remember the last address/data put on the port.
    always_comb begin
        if (drive_s) begin
            hold_a3_d  = a3_s;
            hold_wd3_d = wd3_s;
        end else begin
            hold_a3_d  = hold_a3_q;
            hold_wd3_d = hold_wd3_q;
        end
    end

    // Clear-sequence FSM: walk idx 1..31, then stay in RUN until reset.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_CLEAR: begin
                if (idx_q == IDX_LAST) begin
                    state_d = ST_RUN;
                    idx_d   = idx_q;
                end else begin
                    state_d = ST_CLEAR;
                    idx_d   = idx_q + IDX_ONE;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
                idx_d   = idx_q;
            end
            default: begin
                state_d = ST_CLEAR;
                idx_d   = IDX_ONE;
            end
        endcase
    end

    // FIFO pointer/occupancy update; push and pop may coincide.
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Starvation counter: counts cycles the full FIFO loses to the primary.
    always_comb begin
        if (run_s && fifo_full_s && prim_win_s) begin
            starve_d = starve_q + ST_ONE;
        end else begin
            starve_d = {ST_W{1'b0}};
        end
    end

    // Scoreboard: written FIFO entries clear their bit, issues set (set wins).
    always_comb begin
        pending_d = pending_q;
        if (pop_s && (head_rd_s != IDX_ZERO)) begin
            pending_d[head_rd_s] = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        if (run_s && bus.s_issue && (bus.s_issue_rd != IDX_ZERO)) begin
            pending_d[bus.s_issue_rd] = 1'b1;
        end else begin
            pending_d[0] = 1'b0;
        end
        pending_d[0] = 1'b0;
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            idx_q      <= IDX_ONE;
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            starve_q   <= {ST_W{1'b0}};
            pending_q  <= {NREG{1'b0}};
            hold_a3_q  <= IDX_ZERO;
            hold_wd3_q <= DATA_ZERO;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            pending_q  <= pending_d;
            hold_a3_q  <= hold_a3_d;
            hold_wd3_q <= hold_wd3_d;
        end
    end

    // FIFO storage: accepted secondary results land at the write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_rd_q[i] <= IDX_ZERO;
                fifo_wd_q[i] <= DATA_ZERO;
            end
        end else if (push_s) begin
            fifo_rd_q[wr_ptr_q] <= bus.s_rd;
            fifo_wd_q[wr_ptr_q] <= bus.s_wd;
        end
    end

    assign bus.WE3       = we3_s;
    assign bus.A3        = a3_s;
    assign bus.WD3       = wd3_s;
    assign bus.p_stall   = stall_s;
    assign bus.s_ready   = run_s && !fifo_full_s;
    assign bus.init_busy = !run_s;
    assign bus.hazard    = !run_s || pending_q[bus.chk_rs1] || pending_q[bus.chk_rs2];

endmodule
